// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence presenter: state codes and
// default display timings.
package exibe_sequencia_pkg;

   // State codes double as the value shown on the debug 7-segment display.
   typedef enum logic [3:0] {
      INICIAL = 4'h0,
      CARREGA = 4'h1,
      ACESO   = 4'h2,
      APAGADO = 4'h3,
      FIM     = 4'hF
   } estado_t;

   localparam int T_ACESO_PADRAO   = 1000;
   localparam int T_APAGADO_PADRAO = 250;

endpackage

// File: rtl/exibe_sequencia_if.sv
// Bundle between the presenter, the control unit and the game RAM read port.
// Handshake: iniciar is a level request that is honoured only while the
// presenter is idle (ocupado=0); completion is a single-cycle pronto pulse.
// The RAM read port is asynchronous: mem_dado answers mem_endereco in the
// same cycle.
interface exibe_sequencia_if;
   logic       iniciar;
   logic [3:0] rodada;
   logic [3:0] mem_dado;
   logic [3:0] mem_endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [3:0] db_estado;

   // Control unit / RAM side.
   modport master (
      output iniciar, rodada, mem_dado,
      input  mem_endereco, leds, ocupado, pronto, db_estado
   );

   // Presenter side.
   modport slave (
      input  iniciar, rodada, mem_dado,
      output mem_endereco, leds, ocupado, pronto, db_estado
   );
endinterface

// File: rtl/exibe_sequencia_temporizador.sv
// Display timer: counts cycles while conta_i is high and flags fim_o when
// the count equals the runtime limit. Shared by the lit and dark phases.
module temporizador_exibicao #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera_i,
   input  logic         conta_i,
   input  logic [W-1:0] limite_i,
   output logic         fim_o
);

   logic [W-1:0] contagem_q;
   logic [W-1:0] contagem_d;

   // Next count: clear has priority over counting.
   always_comb begin
      contagem_d = contagem_q;
      if (zera_i)
         contagem_d = '0;
      else if (conta_i)
         contagem_d = contagem_q + 1'b1;
   end

   // Count register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset)
         contagem_q <= '0;
      else
         contagem_q <= contagem_d;
   end

   assign fim_o = (contagem_q == limite_i);

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence presenter: on a start request, walks the game RAM from address 0
// up to the latched rodada, lighting each stored value for T_ACESO cycles
// followed by T_APAGADO dark cycles, then pulses pronto.
module exibe_sequencia
   import exibe_sequencia_pkg::*;
#(
   parameter int T_ACESO   = T_ACESO_PADRAO,
   parameter int T_APAGADO = T_APAGADO_PADRAO,
   parameter int W         = 16
) (
   input  logic              clock,
   input  logic              reset,
   exibe_sequencia_if.slave  bus
);

   estado_t    estado_q, estado_d;
   logic [3:0] led_q, led_d;
   logic [3:0] endereco_q, endereco_d;
   logic [3:0] limite_q, limite_d;

   logic         zera;
   logic         conta;
   logic         fim;
   logic [W-1:0] limite_timer;

   // The timer compares against the last cycle index of the current phase.
   assign limite_timer = (estado_q == ACESO) ? W'(T_ACESO - 1) : W'(T_APAGADO - 1);

   temporizador_exibicao #(.W(W)) u_temporizador (
      .clock    (clock),
      .reset    (reset),
      .zera_i   (zera),
      .conta_i  (conta),
      .limite_i (limite_timer),
      .fim_o    (fim)
   );

   // Next-state, datapath and timer control.
   always_comb begin
      estado_d   = estado_q;
      led_d      = led_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      zera       = 1'b0;
      conta      = 1'b0;
      case (estado_q)
         INICIAL: begin
            if (bus.iniciar) begin
               limite_d   = bus.rodada;
               endereco_d = 4'd0;
               estado_d   = CARREGA;
            end
         end
         CARREGA: begin
            led_d    = bus.mem_dado;
            zera     = 1'b1;
            estado_d = ACESO;
         end
         ACESO: begin
            if (fim) begin
               zera     = 1'b1;
               estado_d = APAGADO;
            end else begin
               conta = 1'b1;
            end
         end
         APAGADO: begin
            if (fim) begin
               zera = 1'b1;
               // Address stops at limite, so it never wraps past 15.
               if (endereco_q == limite_q) begin
                  estado_d = FIM;
               end else begin
                  endereco_d = endereco_q + 4'd1;
                  estado_d   = CARREGA;
               end
            end else begin
               conta = 1'b1;
            end
         end
         FIM: begin
            estado_d = INICIAL;
         end
         default: begin
            estado_d = INICIAL;
         end
      endcase
   end

   // State and datapath registers; reset abandons any run in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= INICIAL;
         led_q      <= 4'd0;
         endereco_q <= 4'd0;
         limite_q   <= 4'd0;
      end else begin
         estado_q   <= estado_d;
         led_q      <= led_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
      end
   end

   // Moore outputs, derived only from registered state and data.
   assign bus.leds         = (estado_q == ACESO) ? led_q : 4'd0;
   assign bus.mem_endereco = endereco_q;
   assign bus.ocupado      = (estado_q != INICIAL);
   assign bus.pronto       = (estado_q == FIM);
   assign bus.db_estado    = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for the sequence presenter with short timings
// (lit 4 cycles, dark 2 cycles, 7 cycles per item).
module tb_exibe_sequencia;
   localparam int TA = 4;
   localparam int TP = 2;
   localparam int PERIODO = 1 + TA + TP;

   logic clock;
   logic reset;
   logic [3:0] ram [16];

   int checks = 0;
   int errors = 0;
   int pronto_cnt;

   // Expected {db_estado, leds, mem_endereco, ocupado, pronto} per cycle.
   logic [13:0] exp_q[$];

   exibe_sequencia_if bus ();

   exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP), .W(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Asynchronous-read RAM model.
   assign bus.mem_dado = ram[bus.mem_endereco];

   // Clock generation.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected outputs after edge e of a run with last index lim.
   function automatic logic [13:0] modelo(input int lim, input int e);
      int total, item, fase;
      logic [3:0] db, ld, ad;
      logic oc, pr;
      total = (lim + 1) * PERIODO;
      db = 4'h0; ld = 4'h0; ad = lim[3:0]; oc = 1'b0; pr = 1'b0;
      if (e == total) begin
         db = 4'hF; oc = 1'b1; pr = 1'b1;
      end else if (e < total) begin
         item = e / PERIODO;
         fase = e % PERIODO;
         ad = item[3:0];
         oc = 1'b1;
         if (fase == 0)
            db = 4'h1;
         else if (fase <= TA) begin
            db = 4'h2;
            ld = ram[item];
         end else
            db = 4'h3;
      end
      return {db, ld, ad, oc, pr};
   endfunction

   task automatic push_run(input int lim, input int n);
      for (int e = 0; e < n; e++) exp_q.push_back(modelo(lim, e));
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(14'd0);
   endtask

   // Advance one edge, sample just after it and compare with the queue head.
   task automatic check_cycle(input string tag);
      logic [13:0] obs, exp_v;
      @(posedge clock);
      #1;
      obs = {bus.db_estado, bus.leds, bus.mem_endereco, bus.ocupado, bus.pronto};
      if (bus.pronto === 1'b1) pronto_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s queue empty obs=%h", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 4'b1111;
      ram[0] = 4'b0001;
      ram[1] = 4'b0010;
      ram[2] = 4'b0100;
      ram[3] = 4'b1000;
      bus.iniciar = 1'b0;
      bus.rodada  = 4'd0;
      reset       = 1'b1;

      // Reset then idle.
      push_idle(13);
      repeat (3) check_cycle("reset");
      reset = 1'b0;
      repeat (10) check_cycle("idle");

      // Single item.
      bus.rodada  = 4'd0;
      bus.iniciar = 1'b1;
      push_run(0, 10);
      check_cycle("run0");
      bus.iniciar = 1'b0;
      repeat (9) check_cycle("run0");

      // Four items, exactly one pronto.
      pronto_cnt  = 0;
      bus.rodada  = 4'd3;
      bus.iniciar = 1'b1;
      push_run(3, 31);
      check_cycle("run3");
      bus.iniciar = 1'b0;
      bus.rodada  = 4'($urandom_range(0, 15));
      repeat (30) check_cycle("run3");
      checks++;
      assert (pronto_cnt === 1) else begin
         errors++;
         $error("FAIL pronto_count obs=%0d exp=1", pronto_cnt);
      end

      // Held start with rodada change mid-run, then automatic restart.
      bus.rodada  = 4'd3;
      bus.iniciar = 1'b1;
      push_run(3, 30);
      for (int i = 0; i < 30; i++) begin
         check_cycle("hold");
         if (i == 9) bus.rodada = 4'd0;
      end
      push_run(0, 10);
      check_cycle("restart");
      bus.iniciar = 1'b0;
      repeat (9) check_cycle("restart");

      // Reset while the second item is lit.
      bus.rodada  = 4'd3;
      bus.iniciar = 1'b1;
      push_run(3, 9);
      check_cycle("abort");
      bus.iniciar = 1'b0;
      repeat (8) check_cycle("abort");
      reset = 1'b1;
      push_idle(1);
      check_cycle("abort_rst");
      reset = 1'b0;
      push_idle(40);
      repeat (40) check_cycle("abort_idle");

      // Sixteen items, address stops at 15.
      bus.rodada  = 4'd15;
      bus.iniciar = 1'b1;
      push_run(15, 115);
      check_cycle("run15");
      bus.iniciar = 1'b0;
      repeat (114) check_cycle("run15");

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_left obs=%0d exp=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
